// File: rtl/ret_addr_stack_pkg.sv
// Shared defaults and the per-cycle stack operation decode for the return-address stack.
// KRV_RAS_DEPTH (if defined) overrides the default stack depth.
`ifndef KRV_RAS_DEPTH
`define KRV_RAS_DEPTH 8
`endif
package ret_addr_stack_pkg;

    localparam int RAS_ADDR_WIDTH = 32;
    localparam int RAS_DEPTH = `KRV_RAS_DEPTH;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } ras_op_e;

    // A push and a pop together only replace the top when there is a top to replace.
    function automatic ras_op_e decodeOp(input logic push, input logic pop, input logic empty);
        ras_op_e op;
        op = OP_NONE;
        if (push && pop && !empty) begin
            op = OP_REPLACE;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_storage.sv
// Return-address entry array: one synchronous write port, one asynchronous read port.
// Entries are deliberately not reset.
module ras_storage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [ADDR_WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [ADDR_WIDTH-1:0] rdata_o
);

    logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_addr_stack.sv
// Checkpointable return-address stack: pointer, count, one-level snapshot and control.
// Defining KRV_RAS_OVERFLOW_WRAP_EN makes a push while full overwrite the oldest entry.
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int ADDR_WIDTH = RAS_ADDR_WIDTH,
    parameter int DEPTH = RAS_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  push_en,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic                  pop_en,
    input  logic                  flush,
    input  logic                  ckpt_save,
    input  logic                  ckpt_restore,
    output logic [ADDR_WIDTH-1:0] top_addr,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic [PTR_W:0]        count,
    output logic                  ckpt_valid,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]      tos_q, tos_d;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic                  ckpt_valid_q, ckpt_valid_d;
    logic [PTR_W-1:0]      ckpt_tos_q, ckpt_tos_d;
    logic [PTR_W:0]        ckpt_cnt_q, ckpt_cnt_d;
    logic [ADDR_WIDTH-1:0] ckpt_top_q, ckpt_top_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wrEn;
    logic [PTR_W-1:0]      wrAddr;
    logic [ADDR_WIDTH-1:0] wrData;
    logic [ADDR_WIDTH-1:0] rdData;
    logic                  isEmpty;
    logic                  isFull;
    ras_op_e               op;

    ras_storage #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_storage (
        .clk_i  (cpu_clk),
        .we_i   (wrEn),
        .waddr_i(wrAddr),
        .wdata_i(wrData),
        .raddr_i(tos_q),
        .rdata_o(rdData)
    );

    assign isEmpty = (cnt_q == '0);
    assign isFull  = (cnt_q == FULL_CNT);
    assign op      = decodeOp(push_en, pop_en, isEmpty);

    assign top_addr    = isEmpty ? '0 : rdData;
    assign stack_empty = isEmpty;
    assign stack_full  = isFull;
    assign count       = cnt_q;
    assign ckpt_valid  = ckpt_valid_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    // Priority: flush, then a live restore, then save alongside the push/pop.
    always_comb begin
        tos_d        = tos_q;
        cnt_d        = cnt_q;
        ckpt_valid_d = ckpt_valid_q;
        ckpt_tos_d   = ckpt_tos_q;
        ckpt_cnt_d   = ckpt_cnt_q;
        ckpt_top_d   = ckpt_top_q;
        ovf_d        = 1'b0;
        unf_d        = 1'b0;
        wrEn         = 1'b0;
        wrAddr       = tos_q;
        wrData       = push_addr;

        if (flush) begin
            tos_d        = '0;
            cnt_d        = '0;
            ckpt_valid_d = 1'b0;
        end else if (ckpt_restore && ckpt_valid_q) begin
            // Snapshot registers already hold the restored values, so a
            // simultaneous save only needs to keep the snapshot valid.
            tos_d        = ckpt_tos_q;
            cnt_d        = ckpt_cnt_q;
            wrEn         = 1'b1;
            wrAddr       = ckpt_tos_q;
            wrData       = ckpt_top_q;
            ckpt_valid_d = ckpt_save;
        end else begin
            if (ckpt_save) begin
                ckpt_tos_d   = tos_q;
                ckpt_cnt_d   = cnt_q;
                ckpt_top_d   = top_addr;
                ckpt_valid_d = 1'b1;
            end

            unique case (op)
                OP_PUSH: begin
                    if (!isFull) begin
                        tos_d  = tos_q + PTR_ONE;
                        cnt_d  = cnt_q + CNT_ONE;
                        wrEn   = 1'b1;
                        wrAddr = tos_q + PTR_ONE;
                    end else begin
                        ovf_d = 1'b1;
`ifdef KRV_RAS_OVERFLOW_WRAP_EN
                        tos_d  = tos_q + PTR_ONE;
                        wrEn   = 1'b1;
                        wrAddr = tos_q + PTR_ONE;
`endif
                    end
                end
                OP_POP: begin
                    if (!isEmpty) begin
                        tos_d = tos_q - PTR_ONE;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    wrEn   = 1'b1;
                    wrAddr = tos_q;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            tos_q        <= '0;
            cnt_q        <= '0;
            ckpt_valid_q <= 1'b0;
            ckpt_tos_q   <= '0;
            ckpt_cnt_q   <= '0;
            ckpt_top_q   <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            tos_q        <= tos_d;
            cnt_q        <= cnt_d;
            ckpt_valid_q <= ckpt_valid_d;
            ckpt_tos_q   <= ckpt_tos_d;
            ckpt_cnt_q   <= ckpt_cnt_d;
            ckpt_top_q   <= ckpt_top_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

endmodule
